id_inst_queue: RTL and testbench
================================

Name: id_inst_queue

Overview:
- Parametrised instruction buffer between the IF stage and the ID decode logic.
- Replaces the single IF→ID valid/allow_in register with a DEPTH-entry circular queue.
- Accepts up to ENQ_W {inst, pc} packets per cycle from IF and presents one packet per cycle to ID.
- Decouples fetch from ID stalls (hazard pause, EX back-pressure) and flushes on a taken branch.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2, and at least ENQ_W.
- ENQ_W, 2, enqueue lanes per cycle; legal values 1 or 2.
- PKT_W, 64, packet width per entry, {inst[31:0], pc[31:0]}.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- if_valid  in  ENQ_W  per-lane packet valid from IF; only contiguous masks from lane 0 are legal.
- if_bus  in  ENQ_W*PKT_W  lane i occupies bits [i*PKT_W +: PKT_W].
- if_allow_in  out  1  queue can accept ENQ_W packets this cycle.
- id_valid  out  1  head packet valid.
- id_bus  out  PKT_W  head packet.
- id_ready_go  in  1  ID consumes the head this cycle; equals ~pause & EX_allow_in.
- br_cancel  in  1  taken branch resolved in ID; flush.
- count  out  CNT_W  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset, asynchronous on resetn low:
  - head_ptr, tail_ptr and count clear to 0.
  - Outputs: id_valid=0, empty=1, full=0, if_allow_in=1.
  - Entry storage is not reset.
- if_allow_in = (DEPTH - count) >= ENQ_W.
  - Combinational on registered count only; it never depends on id_ready_go in the same cycle.
- Enqueue:
  - Occurs when if_allow_in & |if_valid & ~br_cancel.
  - Lane i with if_valid[i]=1 is written to entry (tail_ptr+i) mod DEPTH.
  - tail_ptr advances by popcount(if_valid).
  - All-or-nothing: there is no partial acceptance.
- Dequeue:
  - Occurs when id_valid & id_ready_go & ~br_cancel.
  - head_ptr advances by 1 mod DEPTH.
- id_valid = ~empty; id_bus = entry[head_ptr]. Both are registered-state driven, zero combinational path from IF.
- Latency: a packet enqueued at edge N is visible on id_bus at cycle N+1 at the earliest (see Optional Feature).
- Simultaneous enqueue and dequeue:
  - Both happen in the same cycle.
  - count_next = count + popcount(if_valid) - 1.
  - This is permitted even when full: if_allow_in is 0 then, so no enqueue occurs.
- br_cancel = 1 at an edge:
  - head_ptr = tail_ptr = count = 0.
  - The same-cycle enqueue is dropped, since it is wrong-path fetch.
  - The same-cycle dequeue still counts as consumed by ID: the branch itself leaves.
  - br_cancel has priority over all other updates.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished only by count.
- Illegal if_valid masks (e.g. 2'b10) are not checked and the result is undefined. The bench must not drive them.
- ENQ_W=1: the queue degenerates to a single-lane FIFO; all rules above hold.
- No state machine beyond the pointer/count registers. Implementation is a register-array FIFO, not SRAM.

Optional Feature:
- Macro: ID_QUEUE_BYPASS_EN.
- Defined:
  - When empty & if_valid[0] & ~br_cancel, lane 0 is driven combinationally onto id_bus with id_valid=1.
  - If id_ready_go=1 in that cycle, lane 0 is consumed and not written. Only the remaining lanes are enqueued, starting at tail_ptr.
  - If id_ready_go=0, normal enqueue occurs.
  - Zero-cycle latency through an empty queue.
- Undefined: id_valid = ~empty strictly; one-cycle minimum latency.

Test Plan:
- Fill/drain, DEPTH=8, ENQ_W=2, id_ready_go=0:
  - Drive 4 cycles of if_valid=2'b11 with pc 0x1c000000..0x1c00001c.
  - Required: full=1 and if_allow_in=0 after the 4th edge.
  - Then id_ready_go=1 for 8 cycles: id_bus pc in order 0x1c000000..0x1c00001c, then empty=1.
- Wrap-around:
  - Sustain 2-in/1-out for 20 cycles, then drain.
  - Required: order preserved across pointer wrap, no packet lost or duplicated.
- Near-full:
  - count=7, if_valid=2'b11.
  - Required: if_allow_in=0 and nothing enqueued, even if id_ready_go=1 that cycle.
  - After that dequeue, count=6 and if_allow_in=1.
- Flush:
  - count=5, br_cancel=1 together with if_valid=2'b11 and id_ready_go=1.
  - Required: next cycle count=0, id_valid=0, no wrong-path pc ever appears on id_bus.
- Async reset:
  - Assert resetn=0 mid-cycle with count=3.
  - Required: id_valid=0 and count=0 immediately, without waiting for a clock edge.
  - Deassert, then enqueue pc 0x1c000100: id_bus pc=0x1c000100 at the next cycle.
- Bypass (ID_QUEUE_BYPASS_EN defined):
  - Queue empty, if_valid=2'b11 with pc 0x1c000200/0x1c000204, id_ready_go=1.
  - Required: same-cycle id_bus pc=0x1c000200; next cycle count=1 with head pc=0x1c000204.

Source files
------------

// File: rtl/id_inst_queue_if.sv
// id_inst_queue_if: IF->queue->ID handshake bundle.
// master is the IF/ID environment, slave is the queue.
interface id_inst_queue_if #(
  parameter int ENQ_W = 2,
  parameter int PKT_W = 64
);
  logic [ENQ_W-1:0]       if_valid;
  logic [ENQ_W*PKT_W-1:0] if_bus;
  logic                   if_allow_in;
  logic                   id_valid;
  logic [PKT_W-1:0]       id_bus;
  logic                   id_ready_go;
  logic                   br_cancel;

  modport master (
    output if_valid,
    output if_bus,
    output id_ready_go,
    output br_cancel,
    input  if_allow_in,
    input  id_valid,
    input  id_bus
  );

  modport slave (
    input  if_valid,
    input  if_bus,
    input  id_ready_go,
    input  br_cancel,
    output if_allow_in,
    output id_valid,
    output id_bus
  );
endinterface

// File: rtl/id_inst_queue.sv
// id_inst_queue: DEPTH-entry IF->ID instruction queue, ENQ_W lanes in, 1 out.
// Define ID_QUEUE_BYPASS_EN for same-cycle pass-through of an empty queue.
module id_inst_queue #(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int PKT_W = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  id_inst_queue_if.slave   q,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ENQ_C = CNT_W'(ENQ_W);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] n_in;
  logic             enq;
  logic             deq;
  logic             byp;
  logic             skip;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  assign q.if_allow_in = (DEPTH_C - count) >= ENQ_C;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ENQ_W; i++)
      pop = pop + CNT_W'(q.if_valid[i]);
  end

`ifdef ID_QUEUE_BYPASS_EN
  assign byp = empty & q.if_valid[0] & ~q.br_cancel;
`else
  assign byp = 1'b0;
`endif

  // lane 0 taken by ID straight from IF is never stored
  assign skip = byp & q.id_ready_go;

  assign enq  = q.if_allow_in & (|q.if_valid) & ~q.br_cancel;
  assign deq  = ~empty & q.id_ready_go & ~q.br_cancel;
  assign n_in = enq ? (pop - CNT_W'(skip)) : '0;

  assign q.id_valid = ~empty | byp;
  assign q.id_bus   = byp ? q.if_bus[PKT_W-1:0] : mem[head];

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (q.if_valid[i] && !(i == 0 && skip))
          mem[tail + PW'(i) - PW'(skip)] <=
            q.if_bus[i*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.br_cancel) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(n_in);
      if (deq)
        head <= head + PW'(1);
      count <= count + n_in - CNT_W'(deq);
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: directed scoreboard bench for the IF->ID queue.
// Covers the bypass case too when ID_QUEUE_BYPASS_EN is defined.
module tb_id_inst_queue;
  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int PKT_W = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  id_inst_queue_if #(.ENQ_W(ENQ_W), .PKT_W(PKT_W)) qi ();

  id_inst_queue #(
    .DEPTH(DEPTH),
    .ENQ_W(ENQ_W),
    .PKT_W(PKT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .q(qi),
    .count(count),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  logic [63:0] sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int last_in = 0;
  logic [31:0] npc;

  function automatic logic [63:0] pkt(logic [31:0] pc);
    return {pc ^ 32'h5a5a_0013, pc};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [1:0] v, logic [31:0] pc,
                       logic rdy, logic canc);
    qi.if_valid    = v;
    qi.if_bus      = {pkt(pc + 32'd4), pkt(pc)};
    qi.id_ready_go = rdy;
    qi.br_cancel   = canc;
  endtask

  // check outputs against the model, cross one edge, update the model
  task automatic cycle();
    logic [1:0]  v;
    logic        rdy;
    logic        canc;
    logic        deq;
    logic        take;
    logic        en;
    logic [63:0] lane [2];
    int          n;
    #1;
    v       = qi.if_valid;
    rdy     = qi.id_ready_go;
    canc    = qi.br_cancel;
    lane[0] = qi.if_bus[63:0];
    lane[1] = qi.if_bus[127:64];
    n       = sb.size();
    take    = 1'b0;
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("allow_in", 64'(qi.if_allow_in), 64'((DEPTH - n) >= ENQ_W));
    if (n > 0) begin
      chk("id_valid", 64'(qi.id_valid), 64'(1));
      chk("id_bus", qi.id_bus, sb[0]);
    end else begin
`ifdef ID_QUEUE_BYPASS_EN
      if (v[0] && !canc) begin
        chk("byp_valid", 64'(qi.id_valid), 64'(1));
        chk("byp_bus", qi.id_bus, lane[0]);
        take = rdy;
      end else begin
        chk("id_valid", 64'(qi.id_valid), 64'(0));
      end
`else
      chk("id_valid", 64'(qi.id_valid), 64'(0));
`endif
    end
    deq = (n > 0) && rdy && !canc;
    en  = !canc && ((DEPTH - n) >= ENQ_W) && (v != 2'b00);
    last_in = 0;
    @(posedge clk);
    if (canc) begin
      sb.delete();
    end else begin
      if (deq)
        void'(sb.pop_front());
      if (en) begin
        for (int i = 0; i < 2; i++) begin
          if (v[i]) begin
            last_in++;
            if (!(i == 0 && take))
              sb.push_back(lane[i]);
          end
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12; k++) begin
      if (sb.size() == 0)
        break;
      drive(2'b00, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("drained", 64'(empty), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #12;
    chk("rst_id_valid", 64'(qi.id_valid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_allow_in", 64'(qi.if_allow_in), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // fill to full, then drain in order
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h1c00_0000 + 32'(k * 8), 1'b0, 1'b0);
      cycle();
    end
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_allow_in", 64'(qi.if_allow_in), 64'(0));
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("fill_empty", 64'(empty), 64'(1));

    // sustained 2-in/1-out across pointer wrap
    npc = 32'h1c00_0040;
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, npc, 1'b1, 1'b0);
      cycle();
      npc = npc + 32'(4 * last_in);
    end
    drain();

    // near-full: 7 entries refuse a 2-lane enqueue
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, npc, 1'b0, 1'b0);
      cycle();
      npc = npc + 32'd8;
    end
    drive(2'b01, npc, 1'b0, 1'b0);
    cycle();
    npc = npc + 32'd4;
    drive(2'b11, npc, 1'b1, 1'b0);
    cycle();
    chk("nf_lanes", 64'(last_in), 64'(0));
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("nf_count", 64'(count), 64'(6));
    chk("nf_allow_in", 64'(qi.if_allow_in), 64'(1));
    drain();

    // flush with 5 entries, wrong-path enqueue and a dequeue together
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, npc, 1'b0, 1'b0);
      cycle();
      npc = npc + 32'd8;
    end
    drive(2'b01, npc, 1'b0, 1'b0);
    cycle();
    npc = npc + 32'd4;
    drive(2'b11, 32'hdead_0000, 1'b1, 1'b1);
    cycle();
    chk("fl_count", 64'(count), 64'(0));
    chk("fl_id_valid", 64'(qi.id_valid), 64'(0));
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 32'h0, 1'b1, 1'b0);
      cycle();
    end

    // asynchronous reset in the middle of a cycle
    drive(2'b11, npc, 1'b0, 1'b0);
    cycle();
    drive(2'b01, npc + 32'd8, 1'b0, 1'b0);
    cycle();
    npc = npc + 32'd12;
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #2;
    chk("ar_pre_count", 64'(count), 64'(3));
    resetn = 1'b0;
    #1;
    chk("ar_id_valid", 64'(qi.id_valid), 64'(0));
    chk("ar_count", 64'(count), 64'(0));
    chk("ar_empty", 64'(empty), 64'(1));
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(2'b01, 32'h1c00_0100, 1'b0, 1'b0);
    cycle();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("ar_pc", 64'(qi.id_bus[31:0]), 64'(32'h1c00_0100));
    drain();

`ifdef ID_QUEUE_BYPASS_EN
    // zero-latency pass-through of lane 0 through an empty queue
    drive(2'b11, 32'h1c00_0200, 1'b1, 1'b0);
    cycle();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("byp_count", 64'(count), 64'(1));
    chk("byp_head", 64'(qi.id_bus[31:0]), 64'(32'h1c00_0204));
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
